// File: rtl/mouse_click_qualifier_if.sv
// Bus between the mouse controller / click consumers and mouse_click_qualifier.
// master: the side that drives the raw button, cursor and enable (testbench or glue).
// slave:  the qualifier itself.
interface mouse_click_qualifier_if;
  logic        enable;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        click;
  logic [11:0] click_xpos;
  logic [11:0] click_ypos;
  logic        left_held;

  modport master (
    output enable,
    output mouse_left,
    output mouse_xpos,
    output mouse_ypos,
    input  click,
    input  click_xpos,
    input  click_ypos,
    input  left_held
  );

  modport slave (
    input  enable,
    input  mouse_left,
    input  mouse_xpos,
    input  mouse_ypos,
    output click,
    output click_xpos,
    output click_ypos,
    output left_held
  );
endinterface

// File: rtl/mouse_click_qualifier.sv
// mouse_click_qualifier: synchronises and debounces the raw left mouse button and
// emits one single-cycle click pulse per qualified press, with the cursor position
// captured when the press first appeared.
// Optional feature: define MOUSE_CLAMP_EN to clamp latched coordinates to the screen.
module mouse_click_qualifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000,
  parameter int unsigned CNT_WIDTH       = 17,
  parameter int unsigned SCREEN_W        = 1024,
  parameter int unsigned SCREEN_H        = 768
) (
  input  logic                   clk,
  input  logic                   rst,
  mouse_click_qualifier_if.slave bus
);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE_CYCLES < 1) begin : gen_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (64'(DEBOUNCE_CYCLES - 1) >= (64'(1) << CNT_WIDTH)) begin : gen_bad_cnt_width
    $error("CNT_WIDTH too small to hold DEBOUNCE_CYCLES-1");
  end
  if (SCREEN_W < 1 || SCREEN_W > 4096 || SCREEN_H < 1 || SCREEN_H > 4096) begin : gen_bad_screen
    $error("SCREEN_W/SCREEN_H must fit the 12-bit coordinate range");
  end

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    StIdle,
    StQualPress,
    StHeld,
    StQualRelease
  } state_e;

  // Synchroniser: bit 0 is the metastability-catching stage, bit 1 is sync_left.
  logic [1:0]           sync_d, sync_q;
  logic                 sync_left;

  state_e               state_d, state_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  logic                 click_d, click_q;
  logic                 held_d, held_q;
  logic [11:0]          xpos_d, xpos_q;
  logic [11:0]          ypos_d, ypos_q;

  // Coordinates as they would be captured at press start.
  logic [11:0]          lat_x, lat_y;

  assign sync_d    = {sync_q[0], bus.mouse_left};
  assign sync_left = sync_q[1];

`ifdef MOUSE_CLAMP_EN
  localparam logic [11:0] XMax = 12'(SCREEN_W - 1);
  localparam logic [11:0] YMax = 12'(SCREEN_H - 1);

  // Clamp the captured cursor to the visible screen area.
  always_comb begin
    lat_x = (bus.mouse_xpos > XMax) ? XMax : bus.mouse_xpos;
    lat_y = (bus.mouse_ypos > YMax) ? YMax : bus.mouse_ypos;
  end
`else
  // Capture the raw cursor unchanged.
  always_comb begin
    lat_x = bus.mouse_xpos;
    lat_y = bus.mouse_ypos;
  end
`endif

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= sync_d;
    end
  end

  // Next-state logic: debounce FSM, counter, click pulse and coordinate capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    click_d = 1'b0;
    xpos_d  = xpos_q;
    ypos_d  = ypos_q;

    unique case (state_q)
      StIdle: begin
        if (sync_left) begin
          state_d = StQualPress;
          cnt_d   = '0;
          xpos_d  = lat_x;
          ypos_d  = lat_y;
        end
      end
      StQualPress: begin
        if (!sync_left) begin
          // Glitch: drop back without a click; coordinates keep the new capture.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          // enable is only looked at here, so a gated press can never click later.
          state_d = StHeld;
          cnt_d   = '0;
          click_d = bus.enable;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHeld: begin
        if (!sync_left) begin
          state_d = StQualRelease;
          cnt_d   = '0;
        end
      end
      StQualRelease: begin
        if (sync_left) begin
          // Release bounce: return to HELD without issuing another click.
          state_d = StHeld;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d == StHeld) || (state_d == StQualRelease);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      click_q <= 1'b0;
      held_q  <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      click_q <= click_d;
      held_q  <= held_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
    end
  end

  assign bus.click      = click_q;
  assign bus.left_held  = held_q;
  assign bus.click_xpos = xpos_q;
  assign bus.click_ypos = ypos_q;

endmodule

// File: tb/tb_mouse_click_qualifier.sv
// Self-checking bench for mouse_click_qualifier with DEBOUNCE_CYCLES=4.
// Reference model: run-length view of the synchronised button level.
module tb_mouse_click_qualifier;

  localparam int unsigned Debounce = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_clicks = 0;

  // Reference model state.
  bit          m_s1, m_s2;
  bit          m_deb;
  int          m_run;
  bit          m_click;
  logic [11:0] m_x, m_y;

  mouse_click_qualifier_if bus ();

  mouse_click_qualifier #(
    .DEBOUNCE_CYCLES(Debounce),
    .CNT_WIDTH      (3),
    .SCREEN_W       (1024),
    .SCREEN_H       (768)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] cap_x(input logic [11:0] v);
`ifdef MOUSE_CLAMP_EN
    return (v > 12'd1023) ? 12'd1023 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [11:0] cap_y(input logic [11:0] v);
`ifdef MOUSE_CLAMP_EN
    return (v > 12'd767) ? 12'd767 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0; m_click = 0;
    m_x = '0; m_y = '0;
  endtask

  // A level change qualifies after Debounce+1 consecutive synchronised samples.
  task automatic model_edge();
    bit s;
    if (!rst) begin
      model_reset();
      return;
    end
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = bus.mouse_left;
    m_click = 0;
    if (s != m_deb) begin
      if (!m_deb && m_run == 0) begin
        m_x = cap_x(bus.mouse_xpos);
        m_y = cap_y(bus.mouse_ypos);
      end
      m_run++;
      if (m_run == Debounce + 1) begin
        if (!m_deb) m_click = bus.enable;
        m_deb = ~m_deb;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step(input logic ml, input logic en, input logic [11:0] x, input logic [11:0] y);
    bus.mouse_left = ml;
    bus.enable     = en;
    bus.mouse_xpos = x;
    bus.mouse_ypos = y;
    @(posedge clk);
    model_edge();
    #1;
    check_val("click", {31'd0, bus.click}, {31'd0, m_click});
    check_val("left_held", {31'd0, bus.left_held}, {31'd0, m_deb});
    check_val("click_xpos", {20'd0, bus.click_xpos}, {20'd0, m_x});
    check_val("click_ypos", {20'd0, bus.click_ypos}, {20'd0, m_y});
    if (bus.click === 1'b1) n_clicks++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_click"}, {31'd0, bus.click}, 32'd0);
    check_val({tag, "_held"}, {31'd0, bus.left_held}, 32'd0);
    check_val({tag, "_x"}, {20'd0, bus.click_xpos}, 32'd0);
    check_val({tag, "_y"}, {20'd0, bus.click_ypos}, 32'd0);
  endtask

  initial begin
    int          lat;
    int unsigned c0;
    logic        lvl;
    int unsigned len;

    bus.mouse_left = 1'b0;
    bus.enable     = 1'b0;
    bus.mouse_xpos = '0;
    bus.mouse_ypos = '0;
    model_reset();
    #12;
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b1, 12'd0, 12'd0);

    // Latency: first edge sampling 1 is edge 0; click follows edge Debounce+2.
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 12'd300, 12'd200);
      if (bus.click === 1'b1 && lat < 0) lat = i;
    end
    check_val("latency_edge", lat, 32'd6);
    check_val("lat_xpos", {20'd0, bus.click_xpos}, 32'd300);
    check_val("lat_ypos", {20'd0, bus.click_ypos}, 32'd200);
    check_val("lat_held", {31'd0, bus.left_held}, 32'd1);
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);
    check_val("release_held", {31'd0, bus.left_held}, 32'd0);

    // Glitch rejection.
    c0 = n_clicks;
    repeat (3) step(1'b1, 1'b1, 12'd10, 12'd20);
    repeat (8) step(1'b0, 1'b1, 12'd10, 12'd20);
    check_val("glitch_clicks", n_clicks - c0, 32'd0);
    check_val("glitch_held", {31'd0, bus.left_held}, 32'd0);

    // Release bounce after a qualified press.
    repeat (10) step(1'b1, 1'b1, 12'd40, 12'd50);
    c0 = n_clicks;
    step(1'b0, 1'b1, 12'd40, 12'd50);
    step(1'b1, 1'b1, 12'd40, 12'd50);
    step(1'b0, 1'b1, 12'd40, 12'd50);
    repeat (8) step(1'b1, 1'b1, 12'd40, 12'd50);
    check_val("bounce_clicks", n_clicks - c0, 32'd0);
    check_val("bounce_held", {31'd0, bus.left_held}, 32'd1);
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);

    // Gated press: enable rises while held, still no click.
    c0 = n_clicks;
    for (int i = 0; i < 14; i++) step(1'b1, (i >= 10), 12'd5, 12'd6);
    check_val("gated_clicks", n_clicks - c0, 32'd0);
    check_val("gated_held", {31'd0, bus.left_held}, 32'd1);
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);
    c0 = n_clicks;
    repeat (10) step(1'b1, 1'b1, 12'd7, 12'd8);
    check_val("regated_clicks", n_clicks - c0, 32'd1);
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);

    // Coordinate capture ignores movement during debounce.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, (i < 3) ? 12'd100 : 12'd900, 12'd60);
    check_val("capture_x", {20'd0, bus.click_xpos}, 32'd100);
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);

    // Off-screen press.
    repeat (10) step(1'b1, 1'b1, 12'd1500, 12'd800);
`ifdef MOUSE_CLAMP_EN
    check_val("clamp_x", {20'd0, bus.click_xpos}, 32'd1023);
    check_val("clamp_y", {20'd0, bus.click_ypos}, 32'd767);
`else
    check_val("raw_x", {20'd0, bus.click_xpos}, 32'd1500);
    check_val("raw_y", {20'd0, bus.click_ypos}, 32'd800);
`endif
    repeat (8) step(1'b0, 1'b1, 12'd0, 12'd0);

    // Reset in the middle of press qualification.
    repeat (4) step(1'b1, 1'b1, 12'd333, 12'd444);
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs_zero("midrst");
    c0 = n_clicks;
    repeat (2) step(1'b1, 1'b1, 12'd333, 12'd444);
    rst = 1'b1;
    repeat (8) step(1'b0, 1'b1, 12'd333, 12'd444);
    check_val("midrst_clicks", n_clicks - c0, 32'd0);

    // Randomised segments of varying length against the model.
    lvl = 1'b0;
    repeat (250) begin
      lvl = ~lvl;
      len = $urandom_range(1, 8);
      repeat (len) begin
        step(lvl, ($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
             12'($urandom_range(0, 4095)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
